// File: rtl/stepper_ramp_pkg.sv
// stepper_ramp_pkg: shared constants, state codes and helpers
// for the stepper ramp controller.
package stepper_ramp_pkg;

  localparam int POS_W      = 32;
  localparam int MIN_PERIOD = 2;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_ACCEL  = 3'd1;
  localparam state_t S_CRUISE = 3'd2;
  localparam state_t S_DECEL  = 3'd3;
  localparam state_t S_DONE   = 3'd4;

  // |d| of a 33-bit difference, saturated to the 32-bit range
  function automatic logic [POS_W-1:0] abs_sat(
    input logic signed [POS_W:0] d
  );
    logic [POS_W:0] m;
    m = d[POS_W] ? -d : d;
    return m[POS_W] ? '1 : m[POS_W-1:0];
  endfunction

endpackage

// File: rtl/stepper_ramp_tick.sv
// stepper_ramp_tick: free-running ramp prescaler, one-cycle tick
// every RAMP_DIV clocks, restarted by a synchronous clear.
module stepper_ramp_tick #(
  parameter int unsigned RAMP_DIV = 5000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(RAMP_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/stepper_ramp_ctrl.sv
// stepper_ramp_ctrl: trapezoidal move sequencer for one stepper channel.
// Define STEPPER_RAMP_ABORT_EN to add the abort (controlled stop) input.
module stepper_ramp_ctrl
  import stepper_ramp_pkg::*;
#(
  parameter int unsigned START_PERIOD = 2000,
  parameter int unsigned ACCEL_DELTA  = 20,
  parameter int unsigned RAMP_DIV     = 5000,
  parameter bit          HOLD_TORQUE  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [POS_W-1:0]        cmd_target,
  input  logic [POS_W-1:0]        cmd_min_period,
  input  logic [POS_W-1:0]        position,
  output logic signed [POS_W-1:0] velocity,
  output logic                    drv_enable,
  output logic                    busy,
  output logic                    done
`ifdef STEPPER_RAMP_ABORT_EN
  ,
  input  logic                    abort
`endif
);

  localparam logic [POS_W-1:0] START = POS_W'(START_PERIOD);
  localparam logic [POS_W-1:0] DELTA = POS_W'(ACCEL_DELTA);
  localparam logic [POS_W-1:0] FLOOR = POS_W'(MIN_PERIOD);

  state_t state;
  logic [POS_W-1:0] target;
  logic [POS_W-1:0] eff_min;
  logic [POS_W-1:0] ceil_p;
  logic [POS_W-1:0] period;
  logic [POS_W-1:0] ramp_steps;
  logic [POS_W-1:0] pos_q;
  logic dir;

  logic tick;
  logic accept;
  logic signed [POS_W:0] diff;
  logic signed [POS_W:0] cmd_diff;
  logic [POS_W-1:0] remaining;
  logic [POS_W-1:0] req_min;
  logic [POS_W-1:0] req_ceil;
  logic [POS_W-1:0] p_dec;
  logic [POS_W-1:0] p_inc;
  logic [POS_W-1:0] acc_next;
  logic [POS_W-1:0] stop_tgt;
  logic moving;
  logic arrived;
  logic moved;
  logic abort_req;

  assign cmd_ready = (state == S_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;

  stepper_ramp_tick #(
    .RAMP_DIV(RAMP_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(accept),
    .tick (tick)
  );

  assign diff = $signed({target[POS_W-1], target})
              - $signed({position[POS_W-1], position});
  assign cmd_diff = $signed({cmd_target[POS_W-1], cmd_target})
                  - $signed({position[POS_W-1], position});

  assign remaining = abs_sat(diff);
  assign moved     = (position != pos_q);

  // passing the target counts as arrival: stop, never reverse
  assign arrived = dir ? (diff[POS_W] || (diff == '0))
                       : !diff[POS_W];

  assign req_min  = (cmd_min_period < FLOOR) ? FLOOR : cmd_min_period;
  assign req_ceil = (START > req_min) ? START : req_min;

  assign p_dec = (period - eff_min > DELTA) ? period - DELTA : eff_min;
  assign p_inc = (ceil_p - period > DELTA) ? period + DELTA : ceil_p;
  assign acc_next = tick ? p_dec : period;

`ifdef STEPPER_RAMP_ABORT_EN
  logic [POS_W-1:0] stop_dist;
  // stop distance mirrors the accel distance, never beyond the target
  assign stop_dist = (ramp_steps < remaining) ? ramp_steps : remaining;
  assign stop_tgt  = dir ? position + stop_dist : position - stop_dist;
  assign abort_req = abort && ((state == S_ACCEL) || (state == S_CRUISE));
`else
  assign stop_tgt  = target;
  assign abort_req = 1'b0;
`endif

  assign moving = (state == S_ACCEL) || (state == S_CRUISE)
               || (state == S_DECEL);

  assign velocity = !moving ? '0
                  : dir ? $signed(period) : -$signed(period);

  assign drv_enable = HOLD_TORQUE | busy;

  always_ff @(posedge clk) begin
    pos_q <= position;
    if (rst) begin
      state      <= S_IDLE;
      target     <= '0;
      eff_min    <= FLOOR;
      ceil_p     <= START;
      period     <= START;
      ramp_steps <= '0;
      dir        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            target     <= cmd_target;
            eff_min    <= req_min;
            ceil_p     <= req_ceil;
            period     <= req_ceil;
            ramp_steps <= '0;
            dir        <= !cmd_diff[POS_W];
            busy       <= 1'b1;
            state      <= (cmd_diff == '0) ? S_DONE : S_ACCEL;
          end
        end
        S_ACCEL: begin
          if (moved && (ramp_steps != '1)) begin
            ramp_steps <= ramp_steps + 1'b1;
          end
          if (arrived) begin
            state <= S_DONE;
          end else if (abort_req) begin
            target <= stop_tgt;
            state  <= S_DECEL;
          end else if (remaining <= ramp_steps) begin
            state <= S_DECEL;
          end else begin
            period <= acc_next;
            if (acc_next == eff_min) begin
              state <= S_CRUISE;
            end
          end
        end
        S_CRUISE: begin
          if (arrived) begin
            state <= S_DONE;
          end else if (abort_req) begin
            target <= stop_tgt;
            state  <= S_DECEL;
          end else if (remaining <= ramp_steps) begin
            state <= S_DECEL;
          end
        end
        S_DECEL: begin
          if (arrived) begin
            state <= S_DONE;
          end else if (tick) begin
            period <= p_inc;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stepper_ramp_ctrl.sv
// tb_stepper_ramp_ctrl: scoreboard bench with a step generator model
// driving position from the controller's velocity word.
module tb_stepper_ramp_ctrl;

  localparam int SP = 40;
  localparam int AD = 2;
  localparam int RD = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic [31:0] cmd_target = '0;
  logic [31:0] cmd_min_period = '0;
  logic signed [31:0] position = '0;
  logic signed [31:0] velocity;
  logic cmd_ready;
  logic drv_enable;
  logic busy;
  logic done;
`ifdef STEPPER_RAMP_ABORT_EN
  logic abort = 1'b0;
`endif

  typedef struct {
    int pos;
    bit chk;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int gcnt = 0;
  int acc_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int vmin = 0;
  int vmax = 0;
  int prev_v = 0;
  int bad_ramp = 0;
  int pos_lo = 0;
  int pos_hi = 0;
  int first_v = 0;
  bit saw_nz = 1'b0;

  always #5 clk = ~clk;

  stepper_ramp_ctrl #(
    .START_PERIOD(SP),
    .ACCEL_DELTA (AD),
    .RAMP_DIV    (RD),
    .HOLD_TORQUE (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_target    (cmd_target),
    .cmd_min_period(cmd_min_period),
    .position      (position),
    .velocity      (velocity),
    .drv_enable    (drv_enable),
    .busy          (busy),
    .done          (done)
`ifdef STEPPER_RAMP_ABORT_EN
    ,
    .abort         (abort)
`endif
  );

  function automatic int vmag(input logic signed [31:0] v);
    return (v < 0) ? -int'(v) : int'(v);
  endfunction

  task automatic check(input string tag, input longint got,
                       input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // generator: one count per 2*(|v|+1) clocks, position kept over rst
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (velocity == 0) begin
      gcnt <= 0;
    end else if (gcnt >= 2 * vmag(velocity) + 1) begin
      gcnt <= 0;
      position <= position + ((velocity > 0) ? 32'sd1 : -32'sd1);
    end else begin
      gcnt <= gcnt + 1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    int v;
    v = vmag(velocity);
    if (cmd_valid && cmd_ready) begin
      acc_cyc  = cyc;
      vmin     = 32'h7fffffff;
      vmax     = 0;
      prev_v   = 0;
      bad_ramp = 0;
      saw_nz   = 1'b0;
      pos_lo   = position;
      pos_hi   = position;
    end else if (busy) begin
      if (v != 0) begin
        saw_nz = 1'b1;
        if (v < vmin) vmin = v;
        if (v > vmax) vmax = v;
      end
      if (prev_v != 0 && v != 0 && v != prev_v) begin
        if ((v - prev_v != AD && prev_v - v != AD)
            || ((cyc - acc_cyc - 1) % RD) != 0) begin
          bad_ramp++;
        end
      end
      prev_v = v;
      if (position < pos_lo) pos_lo = position;
      if (position > pos_hi) pos_hi = position;
    end
    if (done) begin
      done_cyc = cyc;
      done_cnt++;
      if (sb.size() == 0) begin
        check("done_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        if (e.chk) check("final_pos", position, e.pos);
      end
      check("vel_at_done", velocity, 0);
      check("busy_at_done", busy, 0);
    end
  end

  task automatic issue(input int tgt, input int minp, input bit chk);
    int t = 0;
    while (!cmd_ready && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("ready_idle", cmd_ready, 1);
    sb.push_back('{pos: tgt, chk: chk});
    cmd_target = tgt;
    cmd_min_period = minp;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    first_v = velocity;
    check("ready_drop", cmd_ready, 0);
    check("busy_set", busy, 1);
  endtask

  task automatic wait_done(input int budget);
    int n0 = done_cnt;
    int t = 0;
    while (done_cnt == n0 && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("done_seen", done_cnt - n0, 1);
    if (done_cnt == n0) sb.delete();
    check("done_width", done, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("done_once", done_cnt - n0, 1);
  endtask

  initial begin
    int held;
    int t;
`ifdef STEPPER_RAMP_ABORT_EN
    int tgt;
    int apos;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", cmd_ready, 0);
    check("rst_vel", velocity, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_enable", drv_enable, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_ready", cmd_ready, 1);
    check("idle_vel", velocity, 0);
    check("idle_busy", busy, 0);
    check("idle_enable", drv_enable, 1);

    // short reverse move: decel starts before cruise is reached
    issue(-10, 200 / 20, 1'b1);
    check("neg_first_vel", first_v, -SP);
    wait_done(5000);
    check("neg_no_cruise", vmin > 10, 1);
    check("neg_no_overshoot", pos_lo, -10);
    check("neg_never_pos", pos_hi, 0);
    check("neg_ramp", bad_ramp, 0);

    // full trapezoid
    issue(200, 10, 1'b1);
    check("trap_first_vel", first_v, SP);
    wait_done(20000);
    check("trap_cruise", vmin, 10);
    check("trap_peak", vmax, SP);
    check("trap_ramp", bad_ramp, 0);
    check("trap_no_overshoot", pos_hi, 200);
    check("trap_enable", drv_enable, 1);

    // zero-length move
    issue(200, 10, 1'b1);
    check("zero_first_vel", first_v, 0);
    wait_done(50);
    check("zero_no_motion", saw_nz, 0);
    check("zero_latency", done_cyc - acc_cyc, 2);

    // min period 0 clamps to 2
    issue(450, 0, 1'b1);
    check("clamp_first_vel", first_v, SP);
    wait_done(20000);
    check("clamp_cruise", vmin, 2);
    check("clamp_ramp", bad_ramp, 0);

    // min period above start: constant period, no ramp
    issue(451, 5000, 1'b1);
    check("slow_first_vel", first_v, 5000);
    wait_done(12000);
    check("slow_min", vmin, 5000);
    check("slow_max", vmax, 5000);

    // reset during cruise
    issue(2000, 10, 1'b1);
    t = 0;
    while (vmag(velocity) != 10 && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("rstmv_cruise", vmag(velocity), 10);
    repeat (50) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rstmv_vel", velocity, 0);
    check("rstmv_busy", busy, 0);
    check("rstmv_ready", cmd_ready, 0);
    sb.delete();
    rst = 1'b0;
    held = position;
    repeat (20) @(posedge clk);
    #1;
    check("rstmv_hold", position, held);
    issue(held - 7, 10, 1'b1);
    check("rstmv_first_vel", first_v, -SP);
    wait_done(5000);

`ifdef STEPPER_RAMP_ABORT_EN
    tgt = position + 1000;
    issue(tgt, 10, 1'b0);
    t = 0;
    while (vmag(velocity) != 10 && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("abort_cruise", vmag(velocity), 10);
    repeat (30) @(posedge clk);
    #1;
    apos = position;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    wait_done(10000);
    check("abort_short", position < tgt, 1);
    check("abort_past", position >= apos, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
